fd_queue: RTL and testbench

//  Parametrised fetch->decode buffer; successor to the single-entry stall-hold FD register.

---
 rtl/fd_queue_pkg.sv | 30 +++
 rtl/fd_queue_ptr.sv | 33 +++
 rtl/fd_queue.sv | 120 ++++++++++++
 tb/tb_fd_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fd_queue_pkg.sv
// Shared definitions for the fetch->decode queue: packet types, the
// common ENABLE/DISABLE signal encoding and the depth ceiling.
package fd_queue_pkg;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } Signal;

    localparam int FDQ_MAX_DEPTH = 16;
    localparam int FDQ_PC_W      = 16;
    localparam int FDQ_INSTR_W   = 9;

    typedef logic [FDQ_PC_W-1:0]    ProgramCounter;
    typedef logic [FDQ_INSTR_W-1:0] Instruction;

    typedef struct packed {
        ProgramCounter next_pc;
        Instruction    instr;
    } FetchPacket;

    // Bundle a next_pc/instruction pair into one packet word.
    function automatic FetchPacket make_packet(input ProgramCounter pc, input Instruction instr);
        FetchPacket pkt;
        pkt.next_pc = pc;
        pkt.instr   = instr;
        return pkt;
    endfunction

endpackage

// File: rtl/fd_queue_ptr.sv
// Wrap-aware pointer register for the fetch->decode queue.
// Counts 0..DEPTH-1 and wraps to 0; DEPTH need not be a power of two.
// clr has priority over inc and returns the pointer to 0.
module fd_queue_ptr
    import fd_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic at_last;

    assign at_last = (ptr == PTR_W'(DEPTH - 1));

    // Pointer register: clear to 0, otherwise step by one and wrap at the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr == ENABLE) begin
            ptr <= '0;
        end else if (inc == ENABLE) begin
            ptr <= at_last ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fd_queue.sv
// Fetch->decode packet queue holding up to DEPTH {next_pc, instr} packets.
// Valid/ready on both sides, a global stall that freezes all state and a
// flush that discards everything held or arriving this cycle.
// Optional feature macro: FD_QUEUE_BYPASS_EN lets a packet arriving at an
// empty queue reach decode in the same cycle; without it the head always
// comes from storage one cycle after the push.
module fd_queue
    import fd_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = FDQ_PC_W,
    parameter int INSTR_W = FDQ_INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam bit DEPTH_OK = (DEPTH >= 2) && (DEPTH <= FDQ_MAX_DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic not_empty;
    logic full;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_inc;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));

    // A full queue refuses input even when decode pops in the same cycle,
    // so in_ready never depends on out_ready.
    assign in_ready = ~full & (stall == DISABLE) & (flush == DISABLE);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready & (stall == DISABLE);

`ifdef FD_QUEUE_BYPASS_EN
    logic bypass_take;

    assign bypass_take = ~not_empty & in_valid & (stall == DISABLE) & (flush == DISABLE);

    assign out_valid = (not_empty | bypass_take) & (flush == DISABLE);
    assign out_pc    = bypass_take ? in_pc    : pc_mem[rd_ptr];
    assign out_instr = bypass_take ? in_instr : instr_mem[rd_ptr];

    // A bypassed packet consumed immediately never touches storage.
    assign wr_en  = push & ~(bypass_take & out_ready);
    assign rd_inc = pop & not_empty;
`else
    assign out_valid = not_empty & (flush == DISABLE);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];

    assign wr_en  = push;
    assign rd_inc = pop;
`endif

    fd_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    fd_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_inc),
        .ptr (rd_ptr)
    );

    // Packet storage: cleared on reset, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Occupancy: flush empties, push-only grows, pop-only shrinks, both holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush == ENABLE) begin
            count <= '0;
        end else if (wr_en && !rd_inc) begin
            count <= count + CNT_W'(1);
        end else if (!wr_en && rd_inc) begin
            count <= count - CNT_W'(1);
        end
    end

    assert property (@(posedge clk) disable iff (!rst) DEPTH_OK && (count <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fd_queue.sv
// Directed self-checking bench for fd_queue (DEPTH=4, PC_W=16, INSTR_W=9).
// Inputs change 2 time units after the rising edge; outputs are sampled
// 1 time unit after that, well away from the edge.
module tb_fd_queue;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [8:0]  in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [8:0]  out_instr;
    logic [2:0]  count;

    int compared;
    int mismatched;

    fd_queue #(.DEPTH(4), .PC_W(16), .INSTR_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] instrOf(input logic [15:0] pc);
        return {1'b1, pc[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [15:0] pc, input logic orr,
                                 input logic st, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instrOf(pc);
        out_ready = orr;
        stall     = st;
        flush     = fl;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2;

        // Reset state
        checkOutput("rst_count", count, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_pc", out_pc, 0);
        checkOutput("rst_out_instr", out_instr, 0);
        stepClock();
        rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Fill to DEPTH with decode not ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h10 + 16'(i), 1'b0, 1'b0, 1'b0);
            stepClock();
            checkOutput("fill_count", count, 32'(i + 1));
        end
        applyStimulus(1'b1, 16'h14, 1'b0, 1'b0, 1'b0);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_head", out_pc, 16'h10);
        stepClock();
        checkOutput("full_ignored_count", count, 4);

        // Full with a pop pending still refuses the push
        applyStimulus(1'b1, 16'h15, 1'b1, 1'b0, 1'b0);
        checkOutput("full_no_passthru", in_ready, 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", out_valid, 1);
            checkOutput("drain_pc", out_pc, 32'(16'h10 + 16'(i)));
            checkOutput("drain_instr", out_instr, 32'(instrOf(16'h10 + 16'(i))));
            stepClock();
        end
        checkOutput("drain_count", count, 0);
        checkOutput("drain_out_valid", out_valid, 0);

        // Wrap: hold occupancy at 2 while streaming
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 16'h30 + 16'(i), 1'b0, 1'b0, 1'b0);
            stepClock();
        end
        checkOutput("wrap_start_count", count, 2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h32 + 16'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("wrap_head", out_pc, 32'(16'h30 + 16'(i)));
            stepClock();
            checkOutput("wrap_count", count, 2);
        end

        // Stall freezes everything
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h50, 1'b1, 1'b1, 1'b0);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
            stepClock();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_count", count, 2);
        checkOutput("stall_head", out_pc, 16'h3A);

        // Flush at count 3 with an incoming packet
        applyStimulus(1'b1, 16'h3C, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("preflush_count", count, 3);
        applyStimulus(1'b1, 16'h60, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_in_ready", in_ready, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush_count", count, 0);
        checkOutput("postflush_out_valid", out_valid, 0);
        applyStimulus(1'b1, 16'h40, 1'b0, 1'b0, 1'b0);
`ifdef FD_QUEUE_BYPASS_EN
        checkOutput("after_flush_bypass_valid", out_valid, 1);
`else
        checkOutput("after_flush_latency", out_valid, 0);
`endif
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_flush_valid", out_valid, 1);
        checkOutput("after_flush_pc", out_pc, 16'h40);
        checkOutput("after_flush_count", count, 1);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_flush_empty", count, 0);

        // Push into an empty queue with decode ready
        applyStimulus(1'b1, 16'h20, 1'b1, 1'b0, 1'b0);
`ifdef FD_QUEUE_BYPASS_EN
        checkOutput("bypass_valid", out_valid, 1);
        checkOutput("bypass_pc", out_pc, 16'h20);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_count", count, 0);
`else
        checkOutput("nobypass_valid", out_valid, 0);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("nobypass_count", count, 1);
        checkOutput("nobypass_pc", out_pc, 16'h20);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("nobypass_drained", count, 0);
`endif

        // Reset in the middle of operation with count 3
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h70 + 16'(i), 1'b0, 1'b0, 1'b0);
            stepClock();
        end
        checkOutput("prereset_count", count, 3);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_pc", out_pc, 0);
        stepClock();
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        applyStimulus(1'b1, 16'h80, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("postrst_count", count, 1);
        checkOutput("postrst_head", out_pc, 16'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
